// File: rtl/seq_binary_to_bcd.sv
// rtl/seq_binary_to_bcd.sv - multi-cycle shift-add-3 binary to BCD converter
//
// Converts a BIN_WIDTH-bit unsigned value into DIGITS packed BCD digits,
// one binary bit per clock (double dabble). A result wider than DIGITS
// wraps modulo 10^DIGITS and raises o_overflow.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_rst      synchronous reset, active-high
//   i_start    request a conversion; only honoured while idle
//   i_binary   value to convert, sampled on the accepting edge
//   o_busy     conversion in progress
//   o_done     one-cycle pulse when o_bcd/o_overflow take a new result
//   o_bcd      packed BCD result, digit 0 (units) in bits [3:0]
//   o_overflow last converted value exceeded 10^DIGITS-1
module seq_binary_to_bcd #(
   parameter int BIN_WIDTH = 8,
   parameter int DIGITS    = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [BIN_WIDTH-1:0]  i_binary,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [4*DIGITS-1:0]   o_bcd,
   output logic                  o_overflow
);

   localparam int              CW   = $clog2(BIN_WIDTH + 1);
   localparam int              BW4  = 4 * DIGITS;
   localparam logic [CW-1:0]   LAST = CW'(BIN_WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t               state_q, state_d;
   logic [BIN_WIDTH-1:0] shift_q, shift_d;
   logic [BW4-1:0]       bcd_q, bcd_d, adj;
   logic                 ovf_q, ovf_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 busy_d, done_d, oovf_d;
   logic [BW4-1:0]       obcd_d;

   // Add-3 correction on every digit that would reach 10 or more when doubled.
   // Digits are independent 4-bit adds; no carry crosses a digit boundary.
   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      count_d = count_q;
      busy_d  = o_busy;
      done_d  = 1'b0;
      obcd_d  = o_bcd;
      oovf_d  = o_overflow;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               shift_d = i_binary;
               bcd_d   = '0;
               ovf_d   = 1'b0;
               count_d = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // The adjusted top bit falls off the BCD register; it only ever
            // sets when the value no longer fits, so it feeds sticky overflow.
            {bcd_d, shift_d} = {adj[BW4-2:0], shift_q, 1'b0};
            ovf_d   = ovf_q | adj[BW4-1];
            count_d = count_q + CW'(1);
            if (count_q == LAST) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               obcd_d  = bcd_d;
               oovf_d  = ovf_d;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bcd_q      <= '0;
         ovf_q      <= 1'b0;
         count_q    <= '0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_bcd      <= '0;
         o_overflow <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bcd_q      <= bcd_d;
         ovf_q      <= ovf_d;
         count_q    <= count_d;
         o_busy     <= busy_d;
         o_done     <= done_d;
         o_bcd      <= obcd_d;
         o_overflow <= oovf_d;
      end
   end

endmodule

// File: tb/tb_seq_binary_to_bcd.sv
// tb/tb_seq_binary_to_bcd.sv - self-checking bench for seq_binary_to_bcd
module tb_seq_binary_to_bcd;

   logic        clk = 1'b0;
   logic        rst;
   logic        start [3];
   logic [15:0] bin   [3];
   logic        busy  [3];
   logic        done  [3];
   logic        ovf   [3];
   logic [19:0] bcd   [3];
   logic [11:0] bcd0_w;
   logic [7:0]  bcd1_w;
   logic [19:0] bcd2_w;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   seq_binary_to_bcd #(.BIN_WIDTH(8), .DIGITS(3)) u_dut0 (
      .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_binary(bin[0][7:0]),
      .o_busy(busy[0]), .o_done(done[0]), .o_bcd(bcd0_w), .o_overflow(ovf[0]));

   seq_binary_to_bcd #(.BIN_WIDTH(7), .DIGITS(2)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_binary(bin[1][6:0]),
      .o_busy(busy[1]), .o_done(done[1]), .o_bcd(bcd1_w), .o_overflow(ovf[1]));

   seq_binary_to_bcd #(.BIN_WIDTH(16), .DIGITS(5)) u_dut2 (
      .i_clk(clk), .i_rst(rst), .i_start(start[2]), .i_binary(bin[2]),
      .o_busy(busy[2]), .o_done(done[2]), .o_bcd(bcd2_w), .o_overflow(ovf[2]));

   assign bcd[0] = {8'd0, bcd0_w};
   assign bcd[1] = {12'd0, bcd1_w};
   assign bcd[2] = bcd2_w;

   function automatic int bw(input int k);
      case (k)
         0:       return 8;
         1:       return 7;
         default: return 16;
      endcase
   endfunction

   function automatic int dg(input int k);
      case (k)
         0:       return 3;
         1:       return 2;
         default: return 5;
      endcase
   endfunction

   // Reference: decimal digits of value mod 10^digits, via plain arithmetic.
   function automatic logic [31:0] ref_bcd(input int value, input int digits);
      int v = value;
      logic [31:0] r = '0;
      for (int i = 0; i < digits; i++) begin
         r = r | (32'(v % 10) << (4 * i));
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic [31:0] ref_ovf(input int value, input int digits);
      int p = 1;
      for (int i = 0; i < digits; i++) p = p * 10;
      return (value >= p) ? 32'd1 : 32'd0;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_conv(input int k, input int value);
      int          w;
      int          cyc;
      int          nbusy;
      logic [31:0] prev;
      logic        seen;
      w = bw(k);
      @(negedge clk);
      start[k] = 1'b1;
      bin[k]   = 16'(value);
      prev     = 32'(bcd[k]);
      @(negedge clk);
      start[k] = 1'b0;
      bin[k]   = 16'($urandom);
      cyc   = 1;
      nbusy = 0;
      seen  = 1'b0;
      while (cyc < 64) begin
         if (done[k]) begin
            seen = 1'b1;
            break;
         end
         if (busy[k]) nbusy++;
         if (cyc == 2) check("hold_during_conv", 32'(bcd[k]), prev);
         @(negedge clk);
         cyc++;
      end
      check("done_seen", 32'(seen), 32'd1);
      check("latency", 32'(cyc), 32'(w + 1));
      check("busy_cycles", 32'(nbusy), 32'(w));
      check("busy_in_done", 32'(busy[k]), 32'd0);
      check("bcd", 32'(bcd[k]), ref_bcd(value, dg(k)));
      check("overflow", 32'(ovf[k]), ref_ovf(value, dg(k)));
      @(negedge clk);
      check("done_one_cycle", 32'(done[k]), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int v, cnt, guard, ndone, cyc;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         start[k] = 1'b0;
         bin[k]   = '0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check("rst_busy", 32'(busy[k]), 32'd0);
         check("rst_done", 32'(done[k]), 32'd0);
         check("rst_bcd", 32'(bcd[k]), 32'd0);
         check("rst_ovf", 32'(ovf[k]), 32'd0);
      end
      rst = 1'b0;

      // 8-bit / 3-digit directed and random
      do_conv(0, 255);
      do_conv(0, 0);
      for (int i = 0; i < 15; i++) do_conv(0, int'($urandom_range(0, 255)));

      // Exhaustive back-to-back with start held high
      @(negedge clk);
      start[0] = 1'b1;
      bin[0]   = 16'd0;
      @(negedge clk);
      v = 0; cnt = 1; guard = 0;
      while (v < 256 && guard < 5000) begin
         if (done[0]) begin
            check("exh_gap", 32'(cnt), 32'd9);
            check("exh_bcd", 32'(bcd[0]), ref_bcd(v, 3));
            check("exh_ovf", 32'(ovf[0]), 32'd0);
            v++;
            cnt = 0;
            if (v < 256) bin[0] = 16'(v);
            else         start[0] = 1'b0;
         end else begin
            bin[0] = 16'($urandom);
         end
         @(negedge clk);
         cnt++;
         guard++;
      end
      check("exh_count", 32'(v), 32'd256);
      start[0] = 1'b0;
      repeat (12) @(negedge clk);

      // Start pulse while busy is ignored
      start[0] = 1'b1;
      bin[0]   = 16'd42;
      @(negedge clk);
      start[0] = 1'b0;
      cyc = 1;
      repeat (2) begin
         @(negedge clk);
         cyc++;
      end
      start[0] = 1'b1;
      bin[0]   = 16'd7;
      @(negedge clk);
      cyc++;
      start[0] = 1'b0;
      while (!done[0] && cyc < 64) begin
         @(negedge clk);
         cyc++;
      end
      check("hs_latency", 32'(cyc), 32'd9);
      check("hs_bcd", 32'(bcd[0]), 32'h042);
      ndone = 0;
      repeat (20) begin
         @(negedge clk);
         if (done[0]) ndone++;
      end
      check("hs_no_second_done", 32'(ndone), 32'd0);

      // Reset in the middle of a conversion
      start[0] = 1'b1;
      bin[0]   = 16'd200;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_rst_busy", 32'(busy[0]), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", 32'(busy[0]), 32'd0);
      check("midrst_done", 32'(done[0]), 32'd0);
      check("midrst_bcd", 32'(bcd[0]), 32'd0);
      check("midrst_ovf", 32'(ovf[0]), 32'd0);
      ndone = 0;
      repeat (12) begin
         @(negedge clk);
         if (done[0]) ndone++;
      end
      check("midrst_no_done", 32'(ndone), 32'd0);
      do_conv(0, 13);

      // 7-bit / 2-digit overflow behaviour
      do_conv(1, 99);
      do_conv(1, 100);
      do_conv(1, 127);
      do_conv(1, 59);
      for (int i = 0; i < 12; i++) do_conv(1, int'($urandom_range(0, 127)));

      // 16-bit / 5-digit
      do_conv(2, 65535);
      do_conv(2, 10000);
      do_conv(2, 1);
      for (int i = 0; i < 12; i++) do_conv(2, int'($urandom_range(0, 65535)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
